muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, issue strobe from E stage; one op per asserted cycle.
REQ-004 SHALL have port op, input, 3, operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-005 SHALL have port a, input, 32, rs operand.
REQ-006 SHALL have port b, input, 32, rt operand.
REQ-007 SHALL have port busy, output, 1, high while an op is executing; feeds the pipeline's Busy stall term.
REQ-008 SHALL have port hi, output, 32, architectural HI register.
REQ-009 SHALL have port lo, output, 32, architectural LO register.

Function
REQ-010 SHALL implement FSM IDLE and RUN; IDLE -> RUN on start with op in {0,1,2,3,6,7}; RUN -> IDLE when down-counter reaches 1.
REQ-011 SHALL latch op, a and b in the start cycle; later changes to a, b or op SHALL NOT affect the running result.
REQ-012 SHALL load the counter with MUL_LAT=5 for ops 0, 1, 6 and 7, and DIV_LAT=10 for ops 2 and 3.
REQ-013 SHALL raise busy in the cycle after start and hold it for exactly LAT cycles.
REQ-014 SHALL write hi/lo on the edge that ends RUN; new values SHALL be visible in the first cycle busy is low.
REQ-015 SHALL compute MULT as a signed 64-bit product and MULTU as an unsigned 64-bit product; hi receives bits 63:32, lo receives bits 31:0.
REQ-016 SHALL compute DIV and DIVU with lo = quotient and hi = remainder; the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-017 SHALL produce lo=0x80000000 and hi=0 for DIV of 0x80000000 by 0xFFFFFFFF.
REQ-018 SHALL leave hi/lo unchanged for division by zero, while still spending DIV_LAT busy cycles.
REQ-019 SHALL compute MADD as {hi,lo} + signed a*b and MSUB as {hi,lo} - signed a*b, modulo 2^64, using the hi/lo values captured at start.
REQ-020 SHALL make MTHI/MTLO write a into hi/lo on the start edge, with no busy assertion; they are legal only in IDLE.
REQ-021 SHALL ignore start while busy (no relatch, no counter reload); the pipeline stall guarantees this never occurs legally.
REQ-022 SHALL accept a start in the first cycle busy is low (back-to-back ops with zero idle gap).

Reset
REQ-023 SHALL, on rst_n low, immediately force IDLE, counter=0, busy=0, hi=0 and lo=0, regardless of state.
REQ-024 SHALL discard any in-flight op aborted by reset and never write its result.

Configuration
REQ-025 SHALL, with MULDIV_MADD_EN defined, execute ops 6 and 7 per REQ-019.
REQ-026 SHALL, without MULDIV_MADD_EN, treat ops 6 and 7 as no-ops: no busy assertion and no hi/lo change.

Structure
REQ-027 SHALL place the op encodings, MUL_LAT and DIV_LAT in shared package muldiv_pkg, also used by the decoder.
REQ-028 SHALL contain one sub-module, muldiv_core: combinational 64-bit result from the latched op, operands and hi/lo; FSM, counter and registers remain in muldiv_unit.

Verification
REQ-029 SHALL cover: MULT a=0xFFFFFFFF, b=2 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-030 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 SHALL cover: DIV a=-7, b=2 -> busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 SHALL cover: DIVU a=5, b=0 after MTHI 0x11 and MTLO 0x22 -> busy high for 10 cycles; hi=0x11, lo=0x22 unchanged.
REQ-033 SHALL cover: MULT 3*4 with rst_n pulsed low at busy cycle 3 -> busy=0 immediately; hi=lo=0; no late write.
REQ-034 SHALL cover: with MULDIV_MADD_EN, hi=0, lo=0xFFFFFFFF, MADD 1*1 -> hi=1, lo=0; without the macro -> hi/lo unchanged, busy never high.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the HI/LO multiply/divide unit.
//   Operation encodings (also used by the instruction decoder), the
//   execution latencies, the counter type and the FSM state type.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } muldiv_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } muldiv_state_e;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  // Wide enough to hold the longest latency.
  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if -- issue/result bundle between the E stage and muldiv_unit.
//   start : issue strobe, one op per asserted cycle (from E stage)
//   op    : operation code (muldiv_pkg::muldiv_op_e encoding)
//   a, b  : rs / rt operands
//   busy  : high while an op executes; drives the pipeline stall term
//   hi,lo : architectural HI / LO registers
// Handshake: an op is taken on any rising edge where start=1 and busy=0;
// start while busy=1 is ignored, so the issuer must stall on busy. There
// is no separate result valid: hi/lo are correct whenever busy=0.
interface muldiv_if;
  import muldiv_pkg::*;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, output op, output a, output b,
                  input busy, input hi, input lo);
  modport slave  (input start, input op, input a, input b,
                  output busy, output hi, output lo);
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core -- purely combinational datapath for muldiv_unit.
//   op_i        : latched operation code
//   a_i, b_i    : latched operands
//   hi_i, lo_i  : current HI/LO (accumulator source for MADD/MSUB)
//   res_o       : 64-bit result, {hi, lo}
//   wr_o        : result should be written (low for divide by zero and
//                 for ops that do not produce a result here)
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o,
  output logic        wr_o
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic        signed_div, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor;
  logic [31:0] q_mag, r_mag, quot, rem;

  always_comb begin
    a_sx   = {{32{a_i[31]}}, a_i};
    b_sx   = {{32{b_i[31]}}, b_i};
    a_zx   = {32'b0, a_i};
    b_zx   = {32'b0, b_i};
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
  end

  // Signed division is done on magnitudes, then the signs are reapplied:
  // quotient truncates toward zero, remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
  always_comb begin
    signed_div = (op_i == OP_DIV);
    a_neg      = signed_div & a_i[31];
    b_neg      = signed_div & b_i[31];
    a_mag      = a_neg ? (32'd0 - a_i) : a_i;
    b_mag      = b_neg ? (32'd0 - b_i) : b_i;
    // Keep the divider well defined on zero; the result is discarded.
    divisor    = (b_i == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / divisor;
    r_mag      = a_mag % divisor;
    quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem        = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    res_o = 64'd0;
    wr_o  = 1'b0;
    case (muldiv_op_e'(op_i))
      OP_MULT: begin
        res_o = prod_s;
        wr_o  = 1'b1;
      end
      OP_MULTU: begin
        res_o = prod_u;
        wr_o  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_o = {rem, quot};
        wr_o  = (b_i != 32'd0);
      end
      OP_MADD: begin
        res_o = {hi_i, lo_i} + prod_s;
        wr_o  = 1'b1;
      end
      OP_MSUB: begin
        res_o = {hi_i, lo_i} - prod_s;
        wr_o  = 1'b1;
      end
      default: begin
        res_o = 64'd0;
        wr_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- multi-cycle HI/LO multiply/divide unit.
//   clk       : sole clock, rising edge
//   rst_n     : asynchronous active-low reset; clears hi/lo and aborts
//               any op in flight without writing its result
//   bus       : muldiv_if.slave (start/op/a/b in, busy/hi/lo out)
//   dbg_state : current FSM state, for observation only
// Optional feature: define MULDIV_MADD_EN to execute MADD/MSUB; without
// it those codes are accepted as no-ops (no busy, no hi/lo change).
// MTHI/MTLO complete on the start edge itself and never assert busy.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  muldiv_if.slave       bus,
  output muldiv_state_e dbg_state
);

  muldiv_state_e state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0]   core_res;
  logic          core_wr;
  logic          launch;
  cnt_t          launch_lat;

  // hi_q/lo_q cannot change during RUN (starts are ignored there), so
  // they are the accumulator values captured at start for MADD/MSUB.
  muldiv_core u_core (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .res_o (core_res),
    .wr_o  (core_wr)
  );

  // Which ops occupy the unit, and for how long.
  always_comb begin
    launch     = 1'b0;
    launch_lat = cnt_t'(MUL_LAT);
    case (muldiv_op_e'(bus.op))
      OP_MULT, OP_MULTU: launch = 1'b1;
      OP_DIV, OP_DIVU: begin
        launch     = 1'b1;
        launch_lat = cnt_t'(DIV_LAT);
      end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MSUB: launch = 1'b1;
`else
      OP_MADD, OP_MSUB: launch = 1'b0;
`endif
      default: launch = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (launch) begin
            state_d = ST_RUN;
            cnt_d   = launch_lat;
            op_d    = bus.op;
            a_d     = bus.a;
            b_d     = bus.b;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      ST_RUN: begin
        // Counting down from LAT to 1 gives exactly LAT busy cycles.
        if (cnt_q == cnt_t'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (core_wr) begin
            hi_d = core_res[63:32];
            lo_d = core_res[31:0];
          end
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if bus ();
  muldiv_state_e dbg_state;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];   // expected {hi, lo} pairs, pushed hi then lo
  logic [31:0] hi_m, lo_m; // reference architectural state

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: results from arithmetic on the op's definition.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint sa, sb, ps;
    longint unsigned ua, ub;
    int ia, ib;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    lat = 0;
    case (op)
      3'd0: begin {hi_m, lo_m} = ps; lat = 5; end
      3'd1: begin {hi_m, lo_m} = ua * ub; lat = 5; end
      3'd2: begin
        lat = 10;
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo_m = 32'h8000_0000; hi_m = 32'h0;
          end else begin
            ia = $signed(a); ib = $signed(b);
            lo_m = ia / ib; hi_m = ia % ib;
          end
        end
      end
      3'd3: begin
        lat = 10;
        if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: begin
`ifdef MULDIV_MADD_EN
        acc = {hi_m, lo_m};
        if (op == 3'd6) acc = acc + ps;
        else            acc = acc - ps;
        {hi_m, lo_m} = acc;
        lat = 5;
`endif
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the next negedge with start dropped and
  // the operand lines scrambled to prove the unit latched them.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  // Issue, count busy cycles (bounded), check against the model.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, output int cyc);
    int lat;
    model_op(op, a, b, lat);
    exp_q.push_back(hi_m);
    exp_q.push_back(lo_m);
    issue(op, a, b);
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 64'(cyc), 64'(lat));
    check({name, " hi"}, {32'b0, bus.hi}, {32'b0, exp_q.pop_front()});
    check({name, " lo"}, {32'b0, bus.lo}, {32'b0, exp_q.pop_front()});
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi0, lo0, exp_hi, exp_lo;
    int          exp_lat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    int cyc;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, 10};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h5, 32'h6, 32'h0, 32'h8000_0000, 10};
    vecs[5] = '{3'd3, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 10};
    vecs[6] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFD, 10};
    vecs[7] = '{3'd0, 32'hFFFF_FFFD, 32'd4, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5};
`ifdef MULDIV_MADD_EN
    vecs[8] = '{3'd6, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5};
    vecs[9] = '{3'd7, 32'd2, 32'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
`else
    vecs[8] = '{3'd6, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 0};
    vecs[9] = '{3'd7, 32'd2, 32'd3, 32'h0, 32'h0, 32'h0, 32'h0, 0};
`endif

    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    hi_m = 32'd0;
    lo_m = 32'd0;

    // Reset state.
    @(negedge clk);
    check("reset busy", {63'b0, bus.busy}, 64'd0);
    check("reset hi", {32'b0, bus.hi}, 64'd0);
    check("reset lo", {32'b0, bus.lo}, 64'd0);
    check("reset state", {63'b0, dbg_state}, {63'b0, ST_IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; each op follows the previous one with zero idle gap.
    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d mthi", i), 3'd4, vecs[i].hi0, 32'd0, cyc);
      run_op($sformatf("vec%0d mtlo", i), 3'd5, vecs[i].lo0, 32'd0, cyc);
      run_op($sformatf("vec%0d op", i), vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d tbl_cycles", i), 64'(cyc), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d tbl_hi", i), {32'b0, bus.hi}, {32'b0, vecs[i].exp_hi});
      check($sformatf("vec%0d tbl_lo", i), {32'b0, bus.lo}, {32'b0, vecs[i].exp_lo});
    end

    // Start while busy is ignored: MULT 5*6 with a DIV strobe in busy cycle 2.
    begin
      int lat;
      model_op(3'd0, 32'd5, 32'd6, lat);
      issue(3'd0, 32'd5, 32'd6);
      cyc = bus.busy ? 1 : 0;
      issue(3'd2, 32'd100, 32'd1);
      while (bus.busy && cyc < 40) begin
        cyc++;
        @(negedge clk);
      end
      check("ignore busy_cycles", 64'(cyc), 64'd5);
      check("ignore lo", {32'b0, bus.lo}, 64'd30);
      check("ignore hi", {32'b0, bus.hi}, 64'd0);
      repeat (3) @(negedge clk);
      check("ignore no_relaunch", {63'b0, bus.busy}, 64'd0);
    end

    // Reset abort: MULT 3*4, rst_n low during busy cycle 3.
    run_op("abort mthi", 3'd4, 32'h55, 32'd0, cyc);
    run_op("abort mtlo", 3'd5, 32'h66, 32'd0, cyc);
    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    check("abort busy_before", {63'b0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {63'b0, bus.busy}, 64'd0);
    check("abort hi", {32'b0, bus.hi}, 64'd0);
    check("abort lo", {32'b0, bus.lo}, 64'd0);
    check("abort state", {63'b0, dbg_state}, {63'b0, ST_IDLE});
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort late_busy", {63'b0, bus.busy}, 64'd0);
    check("abort late_hi", {32'b0, bus.hi}, 64'd0);
    check("abort late_lo", {32'b0, bus.lo}, 64'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'($urandom_range(0, 200)); rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
